multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle RV32I core variant.
- Sequences a shared datapath in which one ALU, one unified instruction/data memory port, the register file and the PC/IR/ALUOut registers are reused across cycles.
- Decodes opcode/funct fields.
- Issues per-state Moore control plus zero-flag-qualified branch writes.
- Stalls on memory ready.
- Traps on unsupported encodings.

Parameters:
- None.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_arst_n  in  1  asynchronous active-low reset.
- i_operand  in  7  instruction[6:0] from the IR.
- i_funct3  in  3  instruction[14:12].
- i_funct7bit5  in  1  instruction[30].
- i_zeroFlag  in  1  ALU zero flag.
- i_memReady  in  1  memory has completed the current access.
- o_pcWrite  out  1  load PC from result bus.
- o_adrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- o_memWrite  out  1  memory write strobe.
- o_irWrite  out  1  load IR and oldPC.
- o_resultSrc  out  2  result mux: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- o_aluSrcA  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1 register.
- o_aluSrcB  out  2  ALU B select: 00 = rs2 register, 01 = immediate, 10 = constant 4.
- o_aluLogicOperation  out  4  ALU operation: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 SLT.
- o_regWriteEn  out  1  register file write enable.
- o_instrRetired  out  1  one-cycle pulse in the final cycle of each instruction.
- o_illegal  out  1  sticky trap flag.
- o_state  out  4  current state, for debug.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_arst_n is asynchronous, active-low.
- Reset entry: state is forced to FETCH (0) immediately when i_arst_n falls.
- Reset exit: exit is synchronous to i_clk.
- Outputs during reset: while i_arst_n = 0, all enables and strobes are 0 (pcWrite, memWrite, irWrite, regWriteEn, instrRetired) and o_illegal = 0. Select outputs hold their FETCH values.
- Output timing: all outputs are combinational decodes of the state register plus the listed inputs. No output latency beyond the state register.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 11. Codes 12-15 go to TRAP.
- FETCH:
  - Outputs: adrSrc = 0, aluSrcA = 00, aluSrcB = 10, ADD, resultSrc = 10.
  - irWrite = pcWrite = i_memReady.
  - Stays in FETCH while i_memReady = 0; otherwise goes to DECODE.
- DECODE: computes the branch/jump target into ALUOut with aluSrcA = 01, aluSrcB = 01, ADD. Next state by opcode:
  - 0000011 (lw, funct3 = 010) or 0100011 (sw, funct3 = 010) -> MEMADR.
  - 0110011 -> EXECUTER.
  - 0010011 -> EXECUTEI.
  - 1100011 (funct3 = 000) -> BEQ.
  - 1101111 -> JAL.
  - Anything else -> TRAP.
- MEMADR: aluSrcA = 10, aluSrcB = 01, ADD. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adrSrc = 1. Holds until i_memReady, then goes to MEMWB.
- MEMWB: resultSrc = 01, regWriteEn = 1, instrRetired = 1. Next state FETCH.
- MEMWRITE:
  - adrSrc = 1, memWrite = 1, held asserted until i_memReady.
  - instrRetired = i_memReady.
  - Goes to FETCH on i_memReady.
- EXECUTER: aluSrcA = 10, aluSrcB = 00. Next state ALUWB.
- EXECUTEI: aluSrcA = 10, aluSrcB = 01. Next state ALUWB.
- ALU operation decode (EXECUTER and EXECUTEI):
  - funct3 000: ADD, or SUB only when R-type and funct7bit5 = 1. I-type ignores funct7bit5.
  - funct3 010: SLT.
  - funct3 110: OR.
  - funct3 111: AND.
  - Any other funct3: the next state is TRAP instead of ALUWB.
- ALUWB: resultSrc = 00, regWriteEn = 1, instrRetired = 1. Next state FETCH.
- BEQ:
  - aluSrcA = 10, aluSrcB = 00, SUB, resultSrc = 00.
  - pcWrite = i_zeroFlag, instrRetired = 1.
  - Next state FETCH.
- JAL:
  - aluSrcA = 01, aluSrcB = 10, ADD, resultSrc = 00, pcWrite = 1.
  - ALUOut receives oldPC + 4. Next state ALUWB, which writes the link to rd.
- TRAP: all enables 0, o_illegal = 1. Stays in TRAP until reset.
- Cycles per instruction with i_memReady = 1: lw 5, sw 4, R 4, I 4, beq 3, jal 4. Each cycle of i_memReady = 0 in a memory state adds one cycle.
- Exactly one instrRetired pulse per completed instruction. None for a trapped instruction.

Test Plan:
- lw (operand 0000011, funct3 010), memReady = 1 -> o_state sequence 0,1,2,3,4,0. regWriteEn = 1 only in state 4 with resultSrc = 01. Exactly 1 retire pulse.
- sw with memReady held low for 3 cycles in MEMWRITE -> memWrite = 1 for 4 consecutive cycles. instrRetired on the 4th cycle only. Then FETCH.
- R-type funct3 000 with funct7bit5 = 1 -> SUB (0001) in EXECUTER. Same fields on 0010011 -> ADD (0000). Both write in ALUWB.
- beq with zeroFlag = 1 -> pcWrite = 1 in BEQ. With zeroFlag = 0 -> pcWrite = 0. Each takes 3 cycles.
- jal -> states 1,10,8. pcWrite = 1 in JAL, regWriteEn = 1 in ALUWB.
- Opcode 1110011 -> TRAP, o_illegal = 1 and sticky. Asserting i_arst_n = 0 mid-MEMWRITE drops memWrite in the same cycle, o_state = 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I core: sequences the shared ALU, memory port,
// register file and PC/IR/ALUOut registers, stalls on memory ready and traps on bad encodings.
module multicycle_controller (
    input  logic       i_clk,
    input  logic       i_arst_n,
    input  logic [6:0] i_operand,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7bit5,
    input  logic       i_zeroFlag,
    input  logic       i_memReady,
    output logic       o_pcWrite,
    output logic       o_adrSrc,
    output logic       o_memWrite,
    output logic       o_irWrite,
    output logic [1:0] o_resultSrc,
    output logic [1:0] o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic [3:0] o_aluLogicOperation,
    output logic       o_regWriteEn,
    output logic       o_instrRetired,
    output logic       o_illegal,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_e     state_q;
    state_e     state_d;
    logic       is_load;
    logic       is_store;
    logic       is_rtype;
    logic       is_itype;
    logic       is_beq;
    logic       is_jal;
    logic       alu_legal;
    logic [3:0] alu_op;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic       reg_write;
    logic       retire;
    logic       illegal;

    assign is_load  = (i_operand == OP_LOAD)   && (i_funct3 == 3'b010);
    assign is_store = (i_operand == OP_STORE)  && (i_funct3 == 3'b010);
    assign is_rtype = (i_operand == OP_RTYPE);
    assign is_itype = (i_operand == OP_ITYPE);
    assign is_beq   = (i_operand == OP_BRANCH) && (i_funct3 == 3'b000);
    assign is_jal   = (i_operand == OP_JAL);

    // funct7bit5 only selects SUB for register-register ops; immediates never subtract.
    always_comb begin
        alu_op    = ALU_ADD;
        alu_legal = 1'b1;
        case (i_funct3)
            3'b000:  alu_op = ((state_q == EXECUTER) && i_funct7bit5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_op = ALU_SLT;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (i_memReady) state_d = DECODE;
            DECODE: begin
                if (is_load || is_store) state_d = MEMADR;
                else if (is_rtype)       state_d = EXECUTER;
                else if (is_itype)       state_d = EXECUTEI;
                else if (is_beq)         state_d = BEQ;
                else if (is_jal)         state_d = JAL;
                else                     state_d = TRAP;
            end
            MEMADR:   state_d = is_store ? MEMWRITE : MEMREAD;
            MEMREAD:  if (i_memReady) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (i_memReady) state_d = FETCH;
            EXECUTER,
            EXECUTEI: state_d = alu_legal ? ALUWB : TRAP;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            JAL:      state_d = ALUWB;
            TRAP:     state_d = TRAP;
            default:  state_d = TRAP;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) state_q <= FETCH;
        else           state_q <= state_d;
    end

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_ADD;
        reg_write  = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = i_memReady;
                pc_write   = i_memReady;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = i_memReady;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_ctrl  = alu_op;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = alu_op;
            end
            ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_ctrl  = ALU_SUB;
                pc_write  = i_zeroFlag;
                retire    = 1'b1;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            default:  illegal = 1'b1;
        endcase
    end

    // FETCH enables follow i_memReady, so they must be masked while reset is held.
    assign o_pcWrite           = pc_write  & i_arst_n;
    assign o_memWrite          = mem_write & i_arst_n;
    assign o_irWrite           = ir_write  & i_arst_n;
    assign o_regWriteEn        = reg_write & i_arst_n;
    assign o_instrRetired      = retire    & i_arst_n;
    assign o_illegal           = illegal   & i_arst_n;
    assign o_adrSrc            = adr_src;
    assign o_resultSrc         = result_src;
    assign o_aluSrcA           = alu_src_a;
    assign o_aluSrcB           = alu_src_b;
    assign o_aluLogicOperation = alu_ctrl;
    assign o_state             = state_q;

endmodule
